// File: rtl/stopwatch_ctrl.sv
// Stopwatch button front-end: two debounced buttons drive a small FSM that emits count/clear controls.
// Define STOPWATCH_CTRL_SYNC_EN to put a 2-flop synchroniser in front of each debouncer (needed for real pins).

module stopwatch_ctrl_btn #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic btn_i,
  output logic press_o
);

  logic s;

`ifdef STOPWATCH_CTRL_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], btn_i};
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s = sync_q[1];
`else
  assign s = btn_i;
`endif

  logic             db_q;
  logic             db_d;
  logic             db_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any sample that agrees with the accepted level restarts the stability count.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db_d  = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = db_q & ~db_dly_q;

endmodule

module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic start_btn_i,
  input  logic clear_btn_i,
  output logic count_o,
  output logic clear_o,
  output logic busy_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    CLR_ARM  = 2'd2,
    CLR_FIRE = 2'd3
  } state_t;

  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {clear_btn_i, start_btn_i};

  // Bit 0 is Start/Stop, bit 1 is Clear.
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    stopwatch_ctrl_btn #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_btn (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .btn_i   (btn_raw[gi]),
      .press_o (press[gi])
    );
  end

  state_t state_q;
  state_t state_d;
  logic   count_q;
  logic   count_d;
  logic   clear_q;
  logic   clear_d;
  logic   busy_q;
  logic   busy_d;

  // Clear has priority over start; presses during a clear sequence are dropped.
  always_comb begin
    state_d = state_q;
    count_d = 1'b0;
    clear_d = 1'b0;
    busy_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press[1]) begin
          state_d = CLR_ARM;
        end else if (press[0]) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (press[1]) begin
          state_d = CLR_FIRE;
        end else if (press[0]) begin
          state_d = IDLE;
        end
      end
      CLR_ARM:  state_d = CLR_FIRE;
      CLR_FIRE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Decoding from the next state makes the registered outputs track the transition edge.
    count_d = (state_d == RUN) || (state_d == CLR_ARM);
    clear_d = (state_d == CLR_FIRE);
    busy_d  = (state_d == CLR_ARM) || (state_d == CLR_FIRE);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      count_q <= 1'b0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      clear_q <= clear_d;
      busy_q  <= busy_d;
    end
  end

  assign count_o = count_q;
  assign clear_o = clear_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: windowed debounce model plus scheduled output sequences, checked every cycle.
// Honours STOPWATCH_CTRL_SYNC_EN the same way the design does (adds 2 cycles of latency).
module tb_stopwatch_ctrl;

  localparam int D = 4;
`ifdef STOPWATCH_CTRL_SYNC_EN
  localparam int S_STG = 2;
`else
  localparam int S_STG = 0;
`endif
  localparam int LAT = S_STG + D;

  logic clk_i       = 1'b0;
  logic reset_ni    = 1'b0;
  logic start_btn_i = 1'b1;
  logic clear_btn_i = 1'b1;
  logic count_o;
  logic clear_o;
  logic busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .start_btn_i(start_btn_i),
    .clear_btn_i(clear_btn_i),
    .count_o    (count_o),
    .clear_o    (clear_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  // Debounce: accept a new level once the last D samples all disagree with the accepted one.
  // Control: a clear press schedules a fixed list of output triples {count,clear,busy}.
  bit         sh  [0:1][0:1];
  bit         win [0:1][0:15];
  bit         db  [0:1];
  bit         dbp [0:1];
  bit         running;
  logic [2:0] seq [$];
  logic [2:0] exp_out;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      sh[b][0] = 1'b0;
      sh[b][1] = 1'b0;
      for (int k = 0; k < 16; k++) win[b][k] = 1'b0;
      db[b]  = 1'b0;
      dbp[b] = 1'b0;
    end
    running = 1'b0;
    seq.delete();
    exp_out = 3'b000;
  endtask

  task automatic model_step();
    bit raw [0:1];
    bit pr  [0:1];
    bit s;
    bit all_diff;
    raw[0] = start_btn_i;
    raw[1] = clear_btn_i;
    for (int b = 0; b < 2; b++) begin
      pr[b]  = db[b] & ~dbp[b];
      dbp[b] = db[b];
      if (S_STG == 0) begin
        s = raw[b];
      end else begin
        s        = sh[b][1];
        sh[b][1] = sh[b][0];
        sh[b][0] = raw[b];
      end
      for (int k = D - 1; k > 0; k--) win[b][k] = win[b][k-1];
      win[b][0] = s;
      all_diff = 1'b1;
      for (int k = 0; k < D; k++) if (win[b][k] == db[b]) all_diff = 1'b0;
      if (all_diff) db[b] = ~db[b];
    end
    if (seq.size() > 0) begin
      exp_out = seq.pop_front();
    end else if (pr[1]) begin
      if (running) begin
        exp_out = 3'b011;
        seq.push_back(3'b000);
      end else begin
        exp_out = 3'b101;
        seq.push_back(3'b011);
        seq.push_back(3'b000);
      end
      running = 1'b0;
    end else begin
      if (pr[0]) running = ~running;
      exp_out = {running, 2'b00};
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_i or negedge reset_ni);
      if (!reset_ni) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk_i);
      if (check_en) begin
        n_checks++;
        if ({count_o, clear_o, busy_o} !== exp_out) begin
          n_fail++;
          $display("FAIL cycle_cmp t=%0t got count/clear/busy=%b want %b",
                   $time, {count_o, clear_o, busy_o}, exp_out);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk_i);
      #2;
    end
  endtask

  task automatic lit(input string nm, input logic [2:0] want);
    n_checks++;
    if ({count_o, clear_o, busy_o} !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got count/clear/busy=%b want %b",
               nm, $time, {count_o, clear_o, busy_o}, want);
    end else begin
      $display("txn %s t=%0t count/clear/busy=%b", nm, $time, want);
    end
  endtask

  // which: 0 waits for busy_o, 1 waits for clear_o
  task automatic wait_sig(input int which, input int maxc, input string nm);
    int k;
    k = 0;
    while (k < maxc && !((which == 0) ? busy_o : clear_o)) begin
      step();
      k++;
    end
    if (k >= maxc) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: signal still low after %0d cycles, required high", nm, maxc);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hs;
    int hc;
    #1 check_en = 1'b1;

    // Reset held with both buttons pressed.
    step(3);
    lit("reset_hold", 3'b000);

    // Release with start still held: one press after S+D edges.
    reset_ni    = 1'b1;
    clear_btn_i = 1'b0;
    step(LAT);
    lit("start_before_lat", 3'b000);
    step(1);
    lit("start_at_lat", 3'b100);
    start_btn_i = 1'b0;
    step(10);
    lit("release_ignored", 3'b100);

    // Clean stop press.
    start_btn_i = 1'b1;
    step(LAT + 3);
    lit("stop_press", 3'b000);
    start_btn_i = 1'b0;
    step(20);

    // Bounce 1,0,1,0 then steady high: a single toggle, S+D after the final rise.
    start_btn_i = 1'b1; step(1);
    start_btn_i = 1'b0; step(1);
    start_btn_i = 1'b1; step(1);
    start_btn_i = 1'b0; step(1);
    start_btn_i = 1'b1;
    step(LAT);
    lit("bounce_before", 3'b000);
    step(1);
    lit("bounce_toggle", 3'b100);
    start_btn_i = 1'b0;
    step(10);

    // Clear while running: count drops and clear rises together.
    clear_btn_i = 1'b1;
    wait_sig(1, 4 * LAT, "clr_run_wait");
    lit("clr_run_fire", 3'b011);
    step(1);
    lit("clr_run_idle", 3'b000);
    clear_btn_i = 1'b0;
    step(10);

    // Clear while stopped: arm cycle then fire cycle.
    clear_btn_i = 1'b1;
    wait_sig(0, 4 * LAT, "clr_idle_wait");
    lit("clr_idle_arm", 3'b101);
    step(1);
    lit("clr_idle_fire", 3'b011);
    step(1);
    lit("clr_idle_done", 3'b000);
    clear_btn_i = 1'b0;
    step(10);

    // Both buttons debounce on the same edge: clear wins.
    start_btn_i = 1'b1;
    clear_btn_i = 1'b1;
    step(LAT + 4);
    lit("simul_end", 3'b000);
    start_btn_i = 1'b0;
    clear_btn_i = 1'b0;
    step(10);

    // Start press landing in CLR_FIRE is dropped.
    clear_btn_i = 1'b1;
    step(2);
    start_btn_i = 1'b1;
    step(LAT + 6);
    lit("start_in_fire", 3'b000);
    start_btn_i = 1'b0;
    clear_btn_i = 1'b0;
    step(10);

    // Reset asserted during CLR_ARM clears outputs immediately.
    clear_btn_i = 1'b1;
    wait_sig(0, 4 * LAT, "rst_arm_wait");
    #1 reset_ni = 1'b0;
    #1 lit("rst_in_arm", 3'b000);
    step(1);
    reset_ni    = 1'b1;
    clear_btn_i = 1'b0;
    step(10);

    // Randomised button activity with occasional resets.
    hs = 0;
    hc = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hs == 0) begin
        start_btn_i = 1'($urandom_range(0, 1));
        hs = $urandom_range(1, 2 * LAT);
      end
      if (hc == 0) begin
        clear_btn_i = 1'($urandom_range(0, 1));
        hc = $urandom_range(1, 4 * LAT);
      end
      hs--;
      hc--;
      reset_ni = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    reset_ni = 1'b1;
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
